a2d_scheduler: RTL and testbench

- Round-robin conversion sequencer for the off-board ADC128S A2D, which carries left load cell, right load cell, steering pot and battery.
- On each `nxt` request it runs the two-transaction ADC128S protocol through the shared SPI master:
  - first transaction sends the channel address;
  - second transaction retrieves the 12-bit result.
- It latches the result into the register for that channel and advances to the next channel.
- Sits between the top-level Segway control (rider-weight/steer-enable logic, battery monitor) and the SPI master driving A2D_SS_n/SCLK/MOSI/MISO.

---
 rtl/segway_pkg.sv | 23 ++
 rtl/a2d_scheduler_if.sv | 10 +
 rtl/a2d_pause_cnt.sv | 27 ++
 rtl/a2d_scheduler.sv | 120 ++++++++++++
 tb/tb_a2d_scheduler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/segway_pkg.sv
// Shared Segway types and constants for the A2D conversion sequencer.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        PAUSE,
        READ
    } a2d_state_t;

    typedef logic [1:0] a2d_ch_t;

    localparam logic [2:0]  CH_LFT_DEF   = 3'd0;
    localparam logic [2:0]  CH_RGHT_DEF  = 3'd4;
    localparam logic [2:0]  CH_STEER_DEF = 3'd5;
    localparam logic [2:0]  CH_BATT_DEF  = 3'd6;
    localparam logic [10:0] A2D_CMD_PAD  = 11'h000;

    function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, A2D_CMD_PAD};
    endfunction

endpackage

// File: rtl/a2d_scheduler_if.sv
// Handshake between the A2D sequencer and the shared 16-bit SPI master.
interface a2d_scheduler_if;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd;

    modport master (output spi_wrt, output spi_cmd, input spi_done, input spi_rd);
    modport slave  (input spi_wrt, input spi_cmd, output spi_done, output spi_rd);
endinterface

// File: rtl/a2d_pause_cnt.sv
// Loadable down-counter with a zero flag; times the SS_n-high gap between transactions.
module a2d_pause_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/a2d_scheduler.sv
// Round-robin ADC128S sequencer: address transaction, pause, read transaction,
// then latch the 12-bit result for the current channel and advance the rotation.
module a2d_scheduler
    import segway_pkg::*;
#(
    parameter int         PAUSE_CYC = 2,
    parameter logic [2:0] CH_LFT    = CH_LFT_DEF,
    parameter logic [2:0] CH_RGHT   = CH_RGHT_DEF,
    parameter logic [2:0] CH_STEER  = CH_STEER_DEF,
    parameter logic [2:0] CH_BATT   = CH_BATT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               nxt,
    a2d_scheduler_if.master    spi,
    output logic [11:0]        lft_ld,
    output logic [11:0]        rght_ld,
    output logic [11:0]        steer_pot,
    output logic [11:0]        batt,
    output logic               cnv_vld,
    output logic               busy
);

    localparam int CNT_W = (PAUSE_CYC > 2) ? $clog2(PAUSE_CYC) : 1;
    localparam logic [CNT_W-1:0] PAUSE_LD = CNT_W'(PAUSE_CYC - 1);

    a2d_state_t  state;
    a2d_ch_t     ptr;
    logic [15:0] cmd_q;
    logic        accept;
    logic        fire_rd;
    logic        pause_ld;
    logic        pause_zero;
    logic        unused_rd_hi;

    function automatic logic [2:0] ch_of(input a2d_ch_t p);
        case (p)
            2'd0:    return CH_LFT;
            2'd1:    return CH_RGHT;
            2'd2:    return CH_STEER;
            default: return CH_BATT;
        endcase
    endfunction

    // busy still covers the cnv_vld cycle, so a request there is dropped
    assign accept   = (state == IDLE) && nxt && !busy;
    assign fire_rd  = (state == PAUSE) && pause_zero;
    assign pause_ld = (state == ADDR) && spi.spi_done;

    // First strobe and command go out in the accepting cycle, hence combinational
    assign spi.spi_wrt = accept | fire_rd;
    assign spi.spi_cmd = accept ? a2d_cmd(ch_of(ptr)) : cmd_q;

    // ADC128S result is 12 bits; the top nibble of the frame carries nothing
    assign unused_rd_hi = ^spi.spi_rd[15:12];

    a2d_pause_cnt #(
        .W(CNT_W)
    ) u_pause_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pause_ld),
        .load_val (PAUSE_LD),
        .en       (state == PAUSE),
        .zero     (pause_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cmd_q     <= '0;
            busy      <= 1'b0;
            cnv_vld   <= 1'b0;
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else begin
            cnv_vld <= 1'b0;
            if (cnv_vld) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q <= a2d_cmd(ch_of(ptr));
                        busy  <= 1'b1;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (spi.spi_done) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (pause_zero) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (spi.spi_done) begin
                        case (ptr)
                            2'd0:    lft_ld    <= spi.spi_rd[11:0];
                            2'd1:    rght_ld   <= spi.spi_rd[11:0];
                            2'd2:    steer_pot <= spi.spi_rd[11:0];
                            default: batt      <= spi.spi_rd[11:0];
                        endcase
                        cnv_vld <= 1'b1;
                        ptr     <= ptr + 2'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_scheduler.sv
// Randomized self-checking bench for a2d_scheduler against a rotation/register model.
module tb_a2d_scheduler;

    localparam int P_A = 2;
    localparam int P_B = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        nxt5 = 1'b0;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic [11:0] lft5, rght5, steer5, batt5;
    logic        cnv_vld, busy, cnv_vld5, busy5;

    a2d_scheduler_if spi ();
    a2d_scheduler_if spi5 ();

    a2d_scheduler #(.PAUSE_CYC(P_A)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .spi       (spi.master),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_vld   (cnv_vld),
        .busy      (busy)
    );

    a2d_scheduler #(.PAUSE_CYC(P_B)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt5),
        .spi       (spi5.master),
        .lft_ld    (lft5),
        .rght_ld   (rght5),
        .steer_pot (steer5),
        .batt      (batt5),
        .cnv_vld   (cnv_vld5),
        .busy      (busy5)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wrt_cnt = 0, vld_cnt = 0, last_wrt = 0;
    int wrt5_cnt = 0, vld5_cnt = 0, last_wrt5 = 0;
    logic [15:0] cmd_log[$];

    // Reference model: channel table, rotation index, expected result registers
    logic [2:0]  ch_tab [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    logic [11:0] exp_reg [4];
    int          ptr_m;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (spi.spi_wrt) begin
            wrt_cnt++;
            last_wrt = cyc;
            cmd_log.push_back(spi.spi_cmd);
        end
        if (cnv_vld) vld_cnt++;
        if (spi5.spi_wrt) begin
            wrt5_cnt++;
            last_wrt5 = cyc;
        end
        if (cnv_vld5) vld5_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_lft"},   32'(lft_ld),    32'(exp_reg[0]));
        chk({tag, "_rght"},  32'(rght_ld),   32'(exp_reg[1]));
        chk({tag, "_steer"}, 32'(steer_pot), 32'(exp_reg[2]));
        chk({tag, "_batt"},  32'(batt),      32'(exp_reg[3]));
    endtask

    function automatic logic spam_bit(input bit spam);
        return spam && ($urandom_range(0, 2) == 0);
    endfunction

    // One full conversion; the bench plays the SPI master. d1/d2 are clocks from each strobe to done.
    task automatic do_conv(input logic [15:0] rd, input int d1, input int d2, input bit spam);
        logic [15:0] exp_cmd;
        int w0, v0, cd, n;
        exp_cmd = {2'b00, ch_tab[ptr_m], 11'h000};
        w0 = wrt_cnt;
        v0 = vld_cnt;
        cmd_log.delete();
        nxt = 1'b1;
        for (int i = 0; i < d1; i++) begin
            tick();
            nxt = spam_bit(spam);
        end
        chk("busy_run", 32'(busy), 32'd1);
        spi.spi_done = 1'b1;
        spi.spi_rd = 16'($urandom);
        cd = cyc;
        tick();
        spi.spi_done = 1'b0;
        nxt = spam_bit(spam);
        n = 0;
        while (wrt_cnt < w0 + 2 && n < 40) begin
            tick();
            nxt = spam_bit(spam);
            n++;
        end
        chk("wrt2_timeout", 32'(n < 40), 32'd1);
        chk("wrt_gap", 32'(last_wrt - cd), 32'(P_A));
        for (int i = 1; i < d2; i++) begin
            tick();
            nxt = spam_bit(spam);
        end
        spi.spi_done = 1'b1;
        spi.spi_rd = rd;
        nxt = spam_bit(spam);
        tick();
        spi.spi_done = 1'b0;
        spi.spi_rd = 16'($urandom);
        nxt = spam;
        exp_reg[ptr_m] = rd[11:0];
        ptr_m = (ptr_m + 1) % 4;
        chk("cnv_vld_pulse", 32'(cnv_vld), 32'd1);
        chk("busy_in_vld", 32'(busy), 32'd1);
        check_regs("reg_upd");
        tick();
        nxt = 1'b0;
        tick();
        tick();
        chk("busy_clr", 32'(busy), 32'd0);
        chk("wrt_count", 32'(wrt_cnt - w0), 32'd2);
        chk("vld_count", 32'(vld_cnt - v0), 32'd1);
        if (cmd_log.size() >= 2) begin
            chk("cmd_addr", 32'(cmd_log[0]), 32'(exp_cmd));
            chk("cmd_read", 32'(cmd_log[1]), 32'(exp_cmd));
        end else begin
            chk("cmd_log_size", 32'(cmd_log.size()), 32'd2);
        end
    endtask

    initial begin
        int v0, w0, cd, n;
        logic [15:0] rdv;
        spi.spi_done = 1'b0;
        spi.spi_rd = '0;
        spi5.spi_done = 1'b0;
        spi5.spi_rd = '0;
        ptr_m = 0;
        for (int i = 0; i < 4; i++) exp_reg[i] = '0;

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(cnv_vld), 32'd0);
        chk("rst_wrt", 32'(spi.spi_wrt), 32'd0);
        chk("rst_cmd", 32'(spi.spi_cmd), 32'd0);
        check_regs("rst");
        rst_n = 1'b1;
        tick();

        // Directed: slow SPI master, then the rest of the rotation and the wrap
        do_conv(16'hF1A6, 32, 32, 1'b0);
        do_conv(16'h31A0, 5, 7, 1'b0);
        do_conv(16'hA800, 3, 2, 1'b0);
        do_conv(16'h5C00, 1, 1, 1'b0);
        do_conv(16'($urandom), 4, 4, 1'b0);

        // Random timing, random data, nxt spammed while busy
        repeat (24) begin
            do_conv(16'($urandom), $urandom_range(1, 12), $urandom_range(1, 12), 1'b1);
        end

        // Stray done while idle
        v0 = vld_cnt;
        w0 = wrt_cnt;
        spi.spi_done = 1'b1;
        spi.spi_rd = 16'h0FFF;
        tick();
        spi.spi_done = 1'b0;
        tick();
        tick();
        chk("stray_vld", 32'(vld_cnt - v0), 32'd0);
        chk("stray_wrt", 32'(wrt_cnt - w0), 32'd0);
        check_regs("stray");

        // Reset while waiting for the read transaction
        v0 = vld_cnt;
        w0 = wrt_cnt;
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        tick();
        spi.spi_done = 1'b1;
        tick();
        spi.spi_done = 1'b0;
        n = 0;
        while (wrt_cnt < w0 + 2 && n < 40) begin
            tick();
            n++;
        end
        chk("rstrd_wrt2", 32'(n < 40), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 4; i++) exp_reg[i] = '0;
        tick();
        spi.spi_done = 1'b1;
        spi.spi_rd = 16'h0ABC;
        tick();
        spi.spi_done = 1'b0;
        tick();
        tick();
        chk("rstrd_vld", 32'(vld_cnt - v0), 32'd0);
        chk("rstrd_busy", 32'(busy), 32'd0);
        check_regs("rstrd");
        do_conv(16'($urandom), 3, 3, 1'b0);

        // Second instance: longer pause between strobes
        for (int k = 0; k < 2; k++) begin
            w0 = wrt5_cnt;
            rdv = 16'($urandom);
            nxt5 = 1'b1;
            tick();
            nxt5 = 1'b0;
            tick();
            tick();
            spi5.spi_done = 1'b1;
            spi5.spi_rd = 16'($urandom);
            cd = cyc;
            tick();
            spi5.spi_done = 1'b0;
            n = 0;
            while (wrt5_cnt < w0 + 2 && n < 40) begin
                tick();
                n++;
            end
            chk("p5_wrt2", 32'(n < 40), 32'd1);
            chk("p5_gap", 32'(last_wrt5 - cd), 32'(P_B));
            spi5.spi_done = 1'b1;
            spi5.spi_rd = rdv;
            tick();
            spi5.spi_done = 1'b0;
            chk("p5_vld", 32'(cnv_vld5), 32'd1);
            if (k == 0) chk("p5_lft", 32'(lft5), 32'(rdv[11:0]));
            else        chk("p5_rght", 32'(rght5), 32'(rdv[11:0]));
            tick();
        end
        chk("p5_vld_count", 32'(vld5_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
